// File: rtl/risky_mmio.sv
// Memory-mapped host interface: exit/code registers, TX and RX character FIFOs,
// and a free-running 64-bit cycle counter with a coherent high-word snapshot.
module risky_mmio #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned BYTE_W   = 8,
    parameter logic [5:0]  REGION   = 6'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_sel,
    input  logic              mem_oe,
    input  logic              mem_we,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              halt,
    output logic [31:0]       exit_code
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW = TX_AW + 1;
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW = RX_AW + 1;

    localparam logic [3:0] IDX_EXIT   = 4'd0;
    localparam logic [3:0] IDX_CODE   = 4'd1;
    localparam logic [3:0] IDX_TXDATA = 4'd2;
    localparam logic [3:0] IDX_TXSTAT = 4'd3;
    localparam logic [3:0] IDX_RXDATA = 4'd4;
    localparam logic [3:0] IDX_RXSTAT = 4'd5;
    localparam logic [3:0] IDX_CYC_LO = 4'd6;
    localparam logic [3:0] IDX_CYC_HI = 4'd7;

    logic              hit;
    logic [3:0]        idx;
    logic              start, wr_start, rd_start;
    logic              hist_sel, hist_oe, hist_we;
    logic [31:0]       hist_addr;

    logic [BYTE_W-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wptr, tx_rptr;
    logic [TX_CW-1:0]  tx_count;
    logic              tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_drop;
    logic              tx_ovf;

    logic [BYTE_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wptr, rx_rptr;
    logic [RX_CW-1:0]  rx_count;
    logic              rx_full, rx_empty, rx_push, rx_pop;

    logic [31:0]       code;
    logic [63:0]       cyc;
    logic [31:0]       cyc_hi_snap;

    assign hit      = (mem_addr[31:26] == REGION);
    assign idx      = mem_addr[3:0];
    assign mem_sel  = hit & mem_oe;

    // An access starts when a selected strobe differs from last cycle's bus state.
    assign start    = hit && (mem_oe || mem_we) &&
                      !(hist_sel == hit && hist_addr == mem_addr &&
                        hist_oe == mem_oe && hist_we == mem_we);
    assign wr_start = start & mem_we;
    assign rd_start = start & mem_oe;

    assign tx_full     = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty    = (tx_count == '0);
    assign tx_valid    = !tx_empty;
    assign tx_data     = tx_mem[tx_rptr];
    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = wr_start && (idx == IDX_TXDATA);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_drop     = tx_push_req && !tx_push;

    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid & rx_ready;
    // A simultaneous write suppresses the RX pop.
    assign rx_pop   = rd_start && !mem_we && (idx == IDX_RXDATA) && !rx_empty;

    assign exit_code = code;

    // FIFO storage carries no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= mem_wdata[BYTE_W-1:0];
        if (rx_push) rx_mem[rx_wptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_sel    <= 1'b0;
            hist_addr   <= '0;
            hist_oe     <= 1'b0;
            hist_we     <= 1'b0;
            tx_wptr     <= '0;
            tx_rptr     <= '0;
            tx_count    <= '0;
            tx_ovf      <= 1'b0;
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_count    <= '0;
            code        <= '0;
            halt        <= 1'b0;
            cyc         <= '0;
            cyc_hi_snap <= '0;
        end else begin
            hist_sel  <= hit;
            hist_addr <= mem_addr;
            hist_oe   <= mem_oe;
            hist_we   <= mem_we;

            if (tx_push) tx_wptr <= tx_wptr + TX_AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + TX_AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + TX_CW'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - TX_CW'(1);

            if (wr_start && idx == IDX_TXSTAT) tx_ovf <= 1'b0;
            else if (tx_drop)                  tx_ovf <= 1'b1;

            if (rx_push) rx_wptr <= rx_wptr + RX_AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + RX_AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + RX_CW'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - RX_CW'(1);

            if (hit && mem_we && idx == IDX_CODE) code <= mem_wdata;
            if (wr_start && idx == IDX_EXIT && mem_wdata != '0) halt <= 1'b1;

            if (!halt) cyc <= cyc + 64'd1;
            if (rd_start && idx == IDX_CYC_LO) cyc_hi_snap <= cyc[63:32];
        end
    end

    // Read mux; deselected reads return zero.
    always_comb begin
        mem_rdata = '0;
        if (hit) begin
            case (idx)
                IDX_CODE:   mem_rdata = code;
                IDX_TXSTAT: mem_rdata = {13'd0, tx_ovf, tx_empty, tx_full, 16'(tx_count)};
                IDX_RXDATA: mem_rdata = rx_empty ? 32'hFFFF_FFFF : 32'(rx_mem[rx_rptr]);
                IDX_RXSTAT: mem_rdata = {14'd0, rx_empty, rx_full, 16'(rx_count)};
                IDX_CYC_LO: mem_rdata = cyc[31:0];
                IDX_CYC_HI: mem_rdata = cyc_hi_snap;
                default:    mem_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_risky_mmio.sv
// Directed bench for risky_mmio: FIFO ordering/overflow, RX pop semantics,
// halt, counter snapshot coherence and reset behaviour.
module tb_risky_mmio;

    localparam int unsigned BYTE_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata, exit_code;
    logic              mem_sel, mem_oe, mem_we;
    logic [BYTE_W-1:0] tx_data, rx_data;
    logic              tx_valid, tx_ready, rx_valid, rx_ready, halt;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd, rd2;

    risky_mmio dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_sel(mem_sel), .mem_oe(mem_oe), .mem_we(mem_we),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .halt(halt), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [3:0] idx);
        return {6'd2, 22'd0, idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] idx, input logic [31:0] data);
        mem_addr = reg_addr(idx); mem_wdata = data; mem_we = 1'b1;
        tick();
        mem_we = 1'b0;
        tick();
    endtask

    // Captures read data during the start cycle, holds the strobe for n edges.
    task automatic bus_read(input logic [3:0] idx, input int n, output logic [31:0] data);
        mem_addr = reg_addr(idx); mem_oe = 1'b1;
        #1 data = mem_rdata;
        for (int i = 0; i < n; i++) @(posedge clk);
        #1 mem_oe = 1'b0;
        tick();
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_oe = 1'b0; mem_we = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_exit_code", exit_code, 32'd0);
        bus_read(4'd3, 1, rd); check("rst_txstat", rd, 32'h0002_0000);
        bus_read(4'd5, 1, rd); check("rst_rxstat", rd, 32'h0002_0000);

        // TX ordering
        bus_write(4'd2, 32'h41); bus_write(4'd2, 32'h42); bus_write(4'd2, 32'h43);
        bus_read(4'd3, 1, rd); check("tx_stat3", rd, 32'h0000_0003);
        check("tx_valid_up", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        check("tx_d0", 32'(tx_data), 32'h41);
        tick(); check("tx_d1", 32'(tx_data), 32'h42);
        tick(); check("tx_d2", 32'(tx_data), 32'h43);
        tick(); check("tx_drained", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
        bus_read(4'd3, 1, rd); check("tx_stat0", rd, 32'h0002_0000);

        // TX overflow: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) bus_write(4'd2, 32'h10 + 32'(i));
        bus_read(4'd3, 1, rd); check("ovf_stat", rd, 32'h0005_0010);
        bus_write(4'd3, 32'h0);
        bus_read(4'd3, 1, rd); check("ovf_clear", rd, 32'h0001_0010);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_data%0d", i), 32'(tx_data), 32'h10 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        check("ovf_empty", 32'(tx_valid), 32'd0);

        // RX pop, one per access start
        rx_send(8'h0A); rx_send(8'h0B);
        bus_read(4'd5, 1, rd); check("rx_stat2", rd, 32'h0000_0002);
        bus_read(4'd4, 3, rd); check("rx_rd0", rd, 32'h0000_000A);
        bus_read(4'd5, 1, rd); check("rx_stat1", rd, 32'h0000_0001);
        bus_read(4'd4, 3, rd); check("rx_rd1", rd, 32'h0000_000B);
        bus_read(4'd5, 1, rd); check("rx_stat_empty", rd, 32'h0002_0000);
        bus_read(4'd4, 3, rd); check("rx_rd_empty", rd, 32'hFFFF_FFFF);

        // Counter snapshot coherence across the low-word wrap
        force dut.cyc = 64'h0000_0000_FFFF_FFFF;
        mem_addr = reg_addr(4'd6); mem_oe = 1'b1;
        #1 check("cyc_lo", mem_rdata, 32'hFFFF_FFFF);
        tick();
        release dut.cyc;
        mem_oe = 1'b0;
        tick();
        bus_read(4'd7, 1, rd); check("cyc_hi_snap", rd, 32'h0);

        // Halt and exit code
        bus_write(4'd0, 32'h0); check("exit0_nohalt", 32'(halt), 32'd0);
        bus_write(4'd1, 32'h7); check("exit_code", exit_code, 32'd7);
        bus_read(4'd1, 1, rd);  check("code_read", rd, 32'd7);
        mem_addr = {6'd3, 22'd0, 4'd1}; mem_oe = 1'b1;
        #1 check("unsel_rdata", mem_rdata, 32'd0);
        check("unsel_sel", 32'(mem_sel), 32'd0);
        mem_addr = reg_addr(4'd1);
        #1 check("sel_sel", 32'(mem_sel), 32'd1);
        mem_oe = 1'b0;
        tick();
        mem_addr = reg_addr(4'd0); mem_wdata = 32'd1; mem_we = 1'b1;
        #1 check("halt_before_edge", 32'(halt), 32'd0);
        tick();
        check("halt_set", 32'(halt), 32'd1);
        mem_we = 1'b0;
        tick();
        bus_read(4'd6, 1, rd);
        repeat (5) tick();
        bus_read(4'd6, 1, rd2); check("cyc_frozen", rd2, rd);
        bus_write(4'd0, 32'h0); check("halt_sticky", 32'(halt), 32'd1);
        check("exit_code_kept", exit_code, 32'd7);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) bus_write(4'd2, 32'h20 + 32'(i));
        for (int i = 0; i < 5; i++) rx_send(8'h30 + 8'(i));
        bus_read(4'd3, 1, rd); check("pre_rst_txstat", rd, 32'h0000_0005);
        bus_read(4'd5, 1, rd); check("pre_rst_rxstat", rd, 32'h0000_0005);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_halt", 32'(halt), 32'd0);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
        check("mid_rst_code", exit_code, 32'd0);
        bus_read(4'd3, 1, rd); check("mid_rst_txstat", rd, 32'h0002_0000);
        bus_read(4'd5, 1, rd); check("mid_rst_rxstat", rd, 32'h0002_0000);

        // A strobe held through reset starts an access on the first free cycle
        mem_addr = reg_addr(4'd2); mem_wdata = 32'h55; mem_we = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("held_rst_priority", 32'(tx_valid), 32'd0);
        tick();
        mem_we = 1'b0;
        check("held_push_valid", 32'(tx_valid), 32'd1);
        check("held_push_data", 32'(tx_data), 32'h55);
        tick();
        bus_read(4'd3, 1, rd); check("held_push_count", rd, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
